// File: rtl/io_gpio_port.sv
// io_gpio_port: memory-mapped 8-bit output port on the FemtoRV32 data bus.
// Decodes IO-page accesses (mem_addr[22]) and holds port_a. Supports set/clear/toggle
// writes and a blink engine that toggles BLINK_EN bits every BLINK_DIV cycles.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   mem_addr   byte address; bit 22 selects, bits 4:2 index the register
//   mem_wdata  write data
//   mem_wmask  byte write enables; nonzero means write
//   mem_rstrb  read strobe
//   mem_rdata  registered read data, held between selected reads
//   mem_rbusy  always 0
//   mem_wbusy  always 0
//   port_a     registered port output
module io_gpio_port #(
   parameter logic [7:0]  PORT_RESET = 8'h00,
   parameter logic [23:0] DIV_RESET  = 24'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_rbusy,
   output logic        mem_wbusy,
   output logic [7:0]  port_a
);

   logic [7:0]  port_q, port_d;
   logic [7:0]  en_q, en_d;
   logic [23:0] div_q, div_d;
   logic [23:0] cnt_q, cnt_d;
   logic [7:0]  ticks_q, ticks_d;
   logic [31:0] rdata_q, rdata_d;

   logic        sel, wr, wr8, div_wr, tick;
   logic [2:0]  idx;
   logic [23:0] div_new;

   logic unused_bits;
   assign unused_bits = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[1:0], mem_wdata[31:24]};

   assign sel    = mem_addr[22];
   assign idx    = mem_addr[4:2];
   assign wr     = sel & (|mem_wmask);
   assign wr8    = wr & mem_wmask[0];
   assign div_wr = wr & (idx == 3'd5);

   // A tick coinciding with a BLINK_DIV write is suppressed entirely.
   assign tick = (div_q != 24'd0) & (cnt_q == 24'd0) & ~div_wr;

   always_comb begin
      div_new = div_q;
      if (mem_wmask[0]) div_new[7:0]   = mem_wdata[7:0];
      if (mem_wmask[1]) div_new[15:8]  = mem_wdata[15:8];
      if (mem_wmask[2]) div_new[23:16] = mem_wdata[23:16];
   end

   always_comb begin
      port_d  = port_q;
      en_d    = en_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      ticks_d = ticks_q;
      rdata_d = rdata_q;

      // Blink toggle first; a CPU write to port_a below overrides it.
      if (tick) begin
         port_d  = port_q ^ en_q;
         ticks_d = ticks_q + 8'd1;
      end

      if (wr8) begin
         case (idx)
            3'd0:    port_d = mem_wdata[7:0];
            3'd1:    port_d = port_q | mem_wdata[7:0];
            3'd2:    port_d = port_q & ~mem_wdata[7:0];
            3'd3:    port_d = port_q ^ mem_wdata[7:0];
            3'd4:    en_d   = mem_wdata[7:0];
            default: ;
         endcase
      end

      if (wr & (idx == 3'd6)) ticks_d = 8'd0;

      if (div_wr) begin
         div_d = div_new;
         cnt_d = (div_new == 24'd0) ? 24'd0 : div_new - 24'd1;
      end else if (div_q == 24'd0) begin
         cnt_d = 24'd0;
      end else if (cnt_q == 24'd0) begin
         cnt_d = div_q - 24'd1;
      end else begin
         cnt_d = cnt_q - 24'd1;
      end

      // Reads capture pre-update register contents.
      if (sel & mem_rstrb) begin
         case (idx)
            3'd0:    rdata_d = {24'd0, port_q};
            3'd4:    rdata_d = {24'd0, en_q};
            3'd5:    rdata_d = {8'd0, div_q};
            3'd6:    rdata_d = {24'd0, ticks_q};
            default: rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_q  <= PORT_RESET;
         en_q    <= 8'd0;
         div_q   <= DIV_RESET;
         cnt_q   <= 24'd0;
         ticks_q <= 8'd0;
         rdata_q <= 32'd0;
      end else begin
         port_q  <= port_d;
         en_q    <= en_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         ticks_q <= ticks_d;
         rdata_q <= rdata_d;
      end
   end

   assign port_a    = port_q;
   assign mem_rdata = rdata_q;
   assign mem_rbusy = 1'b0;
   assign mem_wbusy = 1'b0;

endmodule

// File: tb/tb_io_gpio_port.sv
// Testbench for io_gpio_port: scoreboard of expected port_a / read data produced by a
// timestamp-based reference model; a monitor process pops and compares each cycle.
module tb_io_gpio_port;
   localparam logic [7:0] PRST = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, mem_rbusy, mem_wbusy;
   logic [7:0]  port_a;

   io_gpio_port #(.PORT_RESET(PRST), .DIV_RESET(24'd0)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .mem_rbusy (mem_rbusy),
      .mem_wbusy (mem_wbusy),
      .port_a    (port_a)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  q_port[$];
   logic [31:0] q_rd[$];
   bit          mon_en = 1'b0;

   // Reference model: the blink schedule is kept as the absolute cycle of the next tick.
   logic [7:0]  m_port, m_en, m_ticks;
   int unsigned m_div;
   longint      m_cyc = 0;
   longint      m_next;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_port  = PRST;
      m_en    = 8'd0;
      m_div   = 0;
      m_ticks = 8'd0;
      m_next  = -1;
   endtask

   // Advance the model by the cycle whose inputs are currently on the bus.
   task automatic model_step();
      bit          sel, wr, wr8, tk, divw;
      int          idx;
      int unsigned nd;
      logic [7:0]  b;
      if (!reset) begin
         model_reset();
         q_port.push_back(m_port);
         m_cyc++;
         return;
      end
      sel = mem_addr[22];
      idx = int'(mem_addr[4:2]);
      wr  = sel && (mem_wmask != 4'd0);
      wr8 = wr && mem_wmask[0];
      b   = mem_wdata[7:0];
      if (sel && mem_rstrb) begin
         case (idx)
            0:       q_rd.push_back({24'd0, m_port});
            4:       q_rd.push_back({24'd0, m_en});
            5:       q_rd.push_back(m_div);
            6:       q_rd.push_back({24'd0, m_ticks});
            default: q_rd.push_back(32'd0);
         endcase
      end
      tk   = (m_div != 0) && (m_cyc == m_next);
      divw = wr && (idx == 5);
      if (divw) begin
         nd = m_div;
         for (int k = 0; k < 3; k++)
            if (mem_wmask[k]) nd = (nd & ~(32'hFF << (8 * k))) | (mem_wdata & (32'hFF << (8 * k)));
         m_div  = nd;
         tk     = 1'b0;
         m_next = (nd == 0) ? -1 : m_cyc + longint'(nd);
      end else if (tk) begin
         m_next = m_cyc + longint'(m_div);
      end
      if (wr8 && idx < 4) begin
         case (idx)
            0:       m_port = b;
            1:       m_port = m_port | b;
            2:       m_port = m_port & ~b;
            default: m_port = m_port ^ b;
         endcase
      end else if (tk) begin
         m_port = m_port ^ m_en;
      end
      if (wr8 && idx == 4) m_en = b;
      if (wr && idx == 6) m_ticks = 8'd0;
      else if (tk) m_ticks = m_ticks + 8'd1;
      q_port.push_back(m_port);
      m_cyc++;
   endtask

   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic r);
      @(negedge clk);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = m;
      mem_rstrb = r;
      mon_en    = 1'b1;
      model_step();
   endtask

   function automatic logic [31:0] ra(input int idx);
      return 32'h0040_0000 | (32'(idx) << 2);
   endfunction

   task automatic wr(input int idx, input logic [31:0] d);
      cyc(ra(idx), d, 4'b0001, 1'b0);
   endtask

   task automatic rd(input int idx);
      cyc(ra(idx), 32'd0, 4'b0000, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(32'd0, 32'd0, 4'b0000, 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wmask = 4'd0;
      mem_rstrb = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_reset_port_a", {24'd0, port_a}, {24'd0, PRST});
      check("async_reset_rdata", mem_rdata, 32'd0);
      model_step();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      model_step();
   endtask

   // Monitor: read data is presented the cycle after a selected strobe.
   bit          rv;
   logic [7:0]  ep;
   logic [31:0] er;
   always @(posedge clk) begin
      if (mon_en) begin
         rv = mem_rstrb && mem_addr[22] && reset;
         #1;
         if (q_port.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL port_a: no expected value queued (t=%0t)", $time);
         end else begin
            ep = q_port.pop_front();
            check("port_a", {24'd0, port_a}, {24'd0, ep});
         end
         check("busy", {30'd0, mem_rbusy, mem_wbusy}, 32'd0);
         if (rv) begin
            if (q_rd.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL mem_rdata: no expected value queued (t=%0t)", $time);
            end else begin
               er = q_rd.pop_front();
               check("mem_rdata", mem_rdata, er);
            end
         end
      end
   end

   logic [31:0] a, d;
   logic [3:0]  m;
   int          ix;

   initial begin
      reset     = 1'b1;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wmask = 4'd0;
      mem_rstrb = 1'b0;
      model_reset();
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_port_a", {24'd0, port_a}, {24'd0, PRST});
      check("reset_rdata", mem_rdata, 32'd0);
      release_reset();

      // Reset values of every register.
      for (int i = 0; i < 8; i++) rd(i);

      // DATA / SET / CLR / TGL.
      wr(0, 32'h3C); wr(1, 32'h03); wr(2, 32'h30); wr(3, 32'hFF);
      rd(1); rd(0);

      // Blink bit 0 with period 4; count ticks, clear, then wrap at period 1.
      wr(0, 32'h10);
      wr(4, 32'h01);
      wr(5, 32'd4);
      idle(40);
      rd(6);
      wr(6, 32'h0);
      rd(6);
      wr(5, 32'd1);
      wr(6, 32'h0);
      idle(256);
      rd(6);

      // CPU write to DATA exactly in a tick cycle wins over the toggle.
      wr(4, 32'hFF);
      wr(5, 32'd4);
      idle(3);
      wr(0, 32'h80);
      idle(6);

      // Byte-lane BLINK_DIV write, masked DATA write, unselected access.
      wr(5, 32'h34);
      cyc(ra(5), 32'h0000_1200, 4'b0010, 1'b0);
      rd(5);
      cyc(ra(0), 32'h0000_5500, 4'b0010, 1'b0);
      cyc(32'h0000_0000, 32'hFF, 4'b1111, 1'b1);
      cyc(32'hFF80_0004, 32'hFF, 4'b1111, 1'b0);
      rd(0);

      // Reset mid-blink, between ticks.
      wr(0, 32'h10);
      wr(4, 32'h01);
      wr(5, 32'd6);
      idle(8);
      rd(0);
      async_reset();
      idle(3);
      release_reset();
      idle(10);
      for (int i = 0; i < 8; i++) rd(i);

      // Randomised traffic with small dividers so ticks interleave with accesses.
      for (int i = 0; i < 800; i++) begin
         ix = int'($urandom_range(0, 7));
         a  = $urandom;
         a[4:2] = 3'(ix);
         a[22]  = ($urandom_range(0, 9) != 0);
         d = $urandom;
         if (ix == 5) d[23:0] = 24'($urandom_range(0, 9));
         m = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'd0;
         cyc(a, d, m, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 8; i++) rd(i);
      idle(1);

      @(posedge clk);
      #3 mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
